// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing the single-ported word memory between fetch (port 0) and data (port 1).
// Define MEM_ARB_RR_EN for round-robin conflict resolution; otherwise the data port has fixed priority.
module mem_port_arbiter #(
    parameter logic [15:0] MEM_ADDR = 16'h1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_rdata,
    output logic        if_resp_err,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [31:0] d_req_wdata,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_rdata,
    output logic        d_resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        owner;        // 0 = fetch, 1 = data
    logic        we_q;
    logic        in_region_q;
    logic        last_grant;
    logic        grant_if;
    logic        grant_d;
    logic        accept;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [31:0] access_rdata;

    assign accept       = grant_if | grant_d;
    assign sel_addr     = grant_d ? d_req_addr  : if_req_addr;
    assign sel_wdata    = grant_d ? d_req_wdata : 32'h0;
    assign access_rdata = (~we_q & in_region_q) ? mem_rdata : 32'h0;
    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (if_req_valid && d_req_valid) begin
`ifdef MEM_ARB_RR_EN
                    grant_if = last_grant;
                    grant_d  = ~last_grant;
`else
                    grant_d  = 1'b1;
`endif
                end else begin
                    grant_if = if_req_valid;
                    grant_d  = d_req_valid;
                end
                state_next = (if_req_valid || d_req_valid) ? ACCESS : IDLE;
            end
            ACCESS: begin
                busy       = 1'b1;
                mem_we     = we_q & in_region_q;
                mem_re     = ~we_q & in_region_q;
                state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset drops any outstanding access: the response registers clear and no strobe follows.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            we_q          <= 1'b0;
            in_region_q   <= 1'b0;
            last_grant    <= 1'b1;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            if_resp_valid <= 1'b0;
            if_resp_rdata <= 32'h0;
            if_resp_err   <= 1'b0;
            d_resp_valid  <= 1'b0;
            d_resp_rdata  <= 32'h0;
            d_resp_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here see pre-edge values.
            state         <= state_next;
            if_resp_valid <= 1'b0;
            d_resp_valid  <= 1'b0;
            last_grant    <= accept ? grant_d : last_grant;
            if (accept) begin
                owner       <= grant_d;
                we_q        <= grant_d & d_req_we;
                in_region_q <= (sel_addr[31:16] == MEM_ADDR);
                mem_addr    <= sel_addr;
                mem_wdata   <= sel_wdata;
            end
            if (state == ACCESS) begin
                if (owner) begin
                    d_resp_valid  <= 1'b1;
                    d_resp_rdata  <= access_rdata;
                    d_resp_err    <= ~in_region_q;
                end else begin
                    if_resp_valid <= 1'b1;
                    if_resp_rdata <= access_rdata;
                    if_resp_err   <= ~in_region_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses on accept, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_req_valid = 1'b0;
    logic        if_req_ready;
    logic [31:0] if_req_addr = 32'h0;
    logic        if_resp_valid;
    logic [31:0] if_resp_rdata;
    logic        if_resp_err;
    logic        d_req_valid = 1'b0;
    logic        d_req_ready;
    logic [31:0] d_req_addr = 32'h0;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_wdata = 32'h0;
    logic        d_resp_valid;
    logic [31:0] d_resp_rdata;
    logic        d_resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_rdata(if_resp_rdata), .if_resp_err(if_resp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata),
        .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory device: read sampled on negedge, write committed on posedge; preload port for setup.
    logic [31:0] mem_arr [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_idx = 10'h0;
    logic [31:0] pl_val = 32'h0;

    always @(negedge clock) if (mem_re) mem_rdata <= mem_arr[mem_addr[11:2]];
    always @(posedge clock) begin
        if (mem_we) mem_arr[mem_addr[11:2]] <= mem_wdata;
        else if (pl_en) mem_arr[pl_idx] <= pl_val;
    end

    typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; int gap; } req_t;
    typedef struct { int due; logic [31:0] rdata; bit err; } resp_t;
    typedef struct { int due; bit we; bit re; logic [31:0] addr; logic [31:0] wdata; } acc_t;

    req_t        if_stim[$];
    req_t        d_stim[$];
    resp_t       if_exp[$];
    resp_t       d_exp[$];
    acc_t        acc_q[$];
    bit          grant_log[$];
    int          grant_cyc[$];
    logic [31:0] ref_mem [16];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    int          re_cnt = 0;
    bit          mon_en = 1'b0;
    acc_t        mon_a;
    resp_t       mon_e;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic req_t mk(input logic [31:0] addr, input bit we, input logic [31:0] wdata, input int gap);
        req_t r;
        r.addr = addr; r.we = we; r.wdata = wdata; r.gap = gap;
        return r;
    endfunction

    // Random address in the 16 modelled words; bits [15:12] and [1:0] vary to exercise aliasing and ignored bits.
    function automatic logic [31:0] rand_addr(input bit allow_out);
        logic [15:0] hi;
        hi = 16'h1000;
        if (allow_out && $urandom_range(0, 7) == 0) begin
            hi = 16'($urandom);
            if (hi == 16'h1000) hi = 16'h2000;
        end
        return {hi, 4'($urandom), 6'b0, 4'($urandom), 2'($urandom)};
    endfunction

    // Reference model: accesses execute atomically in accept order.
    task automatic on_accept(input bit port, input req_t r);
        bit    inr;
        bit    we;
        resp_t e;
        acc_t  a;
        inr     = (r.addr[31:16] == 16'h1000);
        we      = port & r.we;
        e.due   = cyc + 2;
        e.err   = !inr;
        e.rdata = (!we && inr) ? ref_mem[r.addr[5:2]] : 32'h0;
        if (we && inr) ref_mem[r.addr[5:2]] = r.wdata;
        a.due = cyc + 1; a.we = we && inr; a.re = !we && inr; a.addr = r.addr; a.wdata = r.wdata;
        acc_q.push_back(a);
        if (port) d_exp.push_back(e); else if_exp.push_back(e);
        grant_log.push_back(port);
        grant_cyc.push_back(cyc);
    endtask

    task automatic run_port(input bit port);
        req_t r;
        int   waited;
        while (port ? (d_stim.size() != 0) : (if_stim.size() != 0)) begin
            if (port) r = d_stim.pop_front(); else r = if_stim.pop_front();
            repeat (r.gap) begin @(posedge clock); #1; end
            if (port) begin
                d_req_valid = 1'b1; d_req_addr = r.addr; d_req_we = r.we; d_req_wdata = r.wdata;
            end else begin
                if_req_valid = 1'b1; if_req_addr = r.addr;
            end
            waited = 0;
            while (1) begin
                @(negedge clock);
                if (port ? d_req_ready : if_req_ready) begin
                    on_accept(port, r);
                    break;
                end
                waited++;
                if (waited > 40) begin
                    chk1(port ? "d_accept_timeout" : "if_accept_timeout", port ? d_req_ready : if_req_ready, 1'b1);
                    break;
                end
            end
            @(posedge clock); #1;
            if (port) d_req_valid = 1'b0; else if_req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((if_exp.size() + d_exp.size() + acc_q.size()) != 0 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check("drain_timeout", 32'(if_exp.size() + d_exp.size() + acc_q.size()), 32'h0);
        @(posedge clock); #1;
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] v);
        pl_en = 1'b1; pl_idx = {6'b0, idx}; pl_val = v;
        @(posedge clock); #1;
        pl_en = 1'b0;
        ref_mem[idx] = v;
    endtask

    task automatic check_reset_values();
        chk1("rst_if_ready", if_req_ready, 1'b0);
        chk1("rst_d_ready", d_req_ready, 1'b0);
        chk1("rst_if_resp_valid", if_resp_valid, 1'b0);
        chk1("rst_d_resp_valid", d_resp_valid, 1'b0);
        chk1("rst_if_err", if_resp_err, 1'b0);
        chk1("rst_d_err", d_resp_err, 1'b0);
        check("rst_if_rdata", if_resp_rdata, 32'h0);
        check("rst_d_rdata", d_resp_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_mem_re", mem_re, 1'b0);
        chk1("rst_busy", busy, 1'b0);
    endtask

    // Monitor: strobes and responses compared against the scoreboard each negedge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            chk1("ready_exclusive", if_req_ready & d_req_ready, 1'b0);
            if (acc_q.size() != 0 && acc_q[0].due == cyc) begin
                mon_a = acc_q.pop_front();
                chk1("access_busy", busy, 1'b1);
                chk1("access_mem_we", mem_we, mon_a.we);
                chk1("access_mem_re", mem_re, mon_a.re);
                if (mon_a.we || mon_a.re) check("access_mem_addr", {2'b0, mem_addr[31:2]}, {2'b0, mon_a.addr[31:2]});
                if (mon_a.we) check("access_mem_wdata", mem_wdata, mon_a.wdata);
            end else begin
                chk1("idle_busy", busy, 1'b0);
                chk1("idle_mem_we", mem_we, 1'b0);
                chk1("idle_mem_re", mem_re, 1'b0);
            end
            if (if_resp_valid) begin
                if (if_exp.size() == 0) chk1("if_unexpected_resp", if_resp_valid, 1'b0);
                else begin
                    mon_e = if_exp.pop_front();
                    check("if_rdata", if_resp_rdata, mon_e.rdata);
                    chk1("if_err", if_resp_err, mon_e.err);
                    check("if_latency", 32'(cyc), 32'(mon_e.due));
                end
            end else if (if_exp.size() != 0 && if_exp[0].due <= cyc) begin
                chk1("if_missing_resp", if_resp_valid, 1'b1);
                void'(if_exp.pop_front());
            end
            if (d_resp_valid) begin
                if (d_exp.size() == 0) chk1("d_unexpected_resp", d_resp_valid, 1'b0);
                else begin
                    mon_e = d_exp.pop_front();
                    check("d_rdata", d_resp_rdata, mon_e.rdata);
                    chk1("d_err", d_resp_err, mon_e.err);
                    check("d_latency", 32'(cyc), 32'(mon_e.due));
                end
            end else if (d_exp.size() != 0 && d_exp[0].due <= cyc) begin
                chk1("d_missing_resp", d_resp_valid, 1'b1);
                void'(d_exp.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit exp_port;
        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        mon_en = 1'b1;
        reset  = 1'b0;
        for (int i = 0; i < 16; i++) preload(4'(i), $urandom);
        preload(4'd5, 32'hDEADBEEF);

        // Basic read of a preloaded word.
        d_stim.push_back(mk(32'h1000_0014, 1'b0, 32'h0, 0));
        run_port(1'b1);
        wait_idle();

        // Write then fetch the same word; exactly one write strobe cycle.
        we_cnt = 0;
        d_stim.push_back(mk(32'h1000_0020, 1'b1, 32'hCAFEF00D, 0));
        run_port(1'b1);
        if_stim.push_back(mk(32'h1000_0020, 1'b0, 32'h0, 0));
        run_port(1'b0);
        wait_idle();
        check("t2_we_cycles", 32'(we_cnt), 32'd1);

        // Out-of-region read: no strobes, error response.
        we_cnt = 0; re_cnt = 0;
        d_stim.push_back(mk(32'h2000_0000, 1'b0, 32'h0, 0));
        run_port(1'b1);
        wait_idle();
        check("t3_strobes", 32'(we_cnt + re_cnt), 32'd0);

        // Continuous conflict, four requests per port.
        grant_log.delete(); grant_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            if_stim.push_back(mk(rand_addr(1'b0), 1'b0, 32'h0, 0));
            d_stim.push_back(mk(rand_addr(1'b0), 1'($urandom), $urandom, 0));
        end
        fork
            run_port(1'b0);
            run_port(1'b1);
        join
        wait_idle();
        check("t4_grant_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef MEM_ARB_RR_EN
            exp_port = (i % 2) == 1;
`else
            exp_port = i < 4;
`endif
            chk1("t4_grant_order", grant_log[i], exp_port);
            if (i > 0) check("t4_accept_spacing", 32'(grant_cyc[i] - grant_cyc[i-1]), 32'd2);
        end

        // Reset during the ACCESS cycle of a read drops the access.
        d_stim.push_back(mk(32'h1000_0008, 1'b0, 32'h0, 0));
        run_port(1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        if_exp.delete(); d_exp.delete(); acc_q.delete();
        check_reset_values();
        reset = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        d_stim.push_back(mk(32'h1000_0008, 1'b0, 32'h0, 0));
        run_port(1'b1);
        wait_idle();

        // Back-to-back reads on the data port.
        grant_cyc.delete();
        d_stim.push_back(mk(32'h1000_0000, 1'b0, 32'h0, 0));
        d_stim.push_back(mk(32'h1000_0004, 1'b0, 32'h0, 0));
        run_port(1'b1);
        wait_idle();
        check("t6_accept_spacing", 32'(grant_cyc[1] - grant_cyc[0]), 32'd2);

        // Randomized mixed traffic on both ports.
        for (int i = 0; i < 30; i++) begin
            if_stim.push_back(mk(rand_addr(1'b1), 1'b0, 32'h0, $urandom_range(0, 3)));
            d_stim.push_back(mk(rand_addr(1'b1), 1'($urandom), $urandom, $urandom_range(0, 3)));
        end
        fork
            run_port(1'b0);
            run_port(1'b1);
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
